// File: rtl/multicycle_controller.sv
// Multicycle CPU sequencing FSM: shares one memory port between fetch and data
// access, stalls on memReady, counts retired instructions, flags illegal opcodes.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       op,
   input  logic             zero,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             irWrite,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             regWrite,
   output logic [1:0]       regDst,
   output logic [1:0]       memToReg,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [2:0]       aluCtrl,
   output logic [1:0]       pcSrc,
   output logic             halted,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC     = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      HALT     = 4'd10
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_JAL  = 4'b1011;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   state_t curState, nxtState;
   logic   doRetire, setIllegal, illegalReg;
   logic   [2:0] aluOp;

   always_comb begin
      case (op)
         4'b0001: aluOp = ALU_SUB;
         4'b0010: aluOp = 3'b000;
         4'b0011: aluOp = 3'b001;
         4'b0100: aluOp = 3'b111;
         default: aluOp = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) curState <= FETCH;
      else       curState <= nxtState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           illegalReg <= 1'b0;
      else if (setIllegal) illegalReg <= 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         retired <= '0;
      else if (doRetire) retired <= retired + 1'b1;
   end

   always_comb begin
      nxtState   = curState;
      doRetire   = 1'b0;
      setIllegal = 1'b0;
      pcWrite    = 1'b0;
      irWrite    = 1'b0;
      iorD       = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      regWrite   = 1'b0;
      regDst     = 2'b00;
      memToReg   = 2'b00;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b00;
      aluCtrl    = 3'b000;
      pcSrc      = 2'b00;
      case (curState)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            aluCtrl = ALU_ADD;
            if (memReady) begin
               irWrite  = 1'b1;
               pcWrite  = 1'b1;
               nxtState = DECODE;
            end
         end
         DECODE: begin
            // ALUOut picks up PC+4 + (imm<<2) for a possible branch
            aluSrcB = 2'b11;
            aluCtrl = ALU_ADD;
            case (op)
               4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: nxtState = EXEC;
               4'b0110, 4'b0111: nxtState = MEMADDR;
               4'b1000, 4'b1001: nxtState = BRANCH;
               4'b1010, 4'b1011: nxtState = JUMP;
               4'b1111:          nxtState = HALT;
               default: begin
                  nxtState   = FETCH;
                  setIllegal = 1'b1;
               end
            endcase
         end
         EXEC: begin
            aluSrcA  = 1'b1;
            aluSrcB  = (op == OP_ADDI) ? 2'b10 : 2'b00;
            aluCtrl  = aluOp;
            nxtState = ALUWB;
         end
         ALUWB: begin
            regWrite = 1'b1;
            regDst   = (op == OP_ADDI) ? 2'b00 : 2'b01;
            doRetire = 1'b1;
            nxtState = FETCH;
         end
         MEMADDR: begin
            aluSrcA  = 1'b1;
            aluSrcB  = 2'b10;
            aluCtrl  = ALU_ADD;
            nxtState = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (memReady) nxtState = MEMWB;
         end
         MEMWB: begin
            regWrite = 1'b1;
            memToReg = 2'b01;
            doRetire = 1'b1;
            nxtState = FETCH;
         end
         MEMWRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            if (memReady) begin
               doRetire = 1'b1;
               nxtState = FETCH;
            end
         end
         BRANCH: begin
            aluSrcA  = 1'b1;
            aluCtrl  = ALU_SUB;
            pcSrc    = 2'b01;
            pcWrite  = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
            doRetire = 1'b1;
            nxtState = FETCH;
         end
         JUMP: begin
            pcSrc   = 2'b10;
            pcWrite = 1'b1;
            if (op == OP_JAL) begin
               regWrite = 1'b1;
               regDst   = 2'b10;
               memToReg = 2'b10;
            end
            doRetire = 1'b1;
            nxtState = FETCH;
         end
         HALT: nxtState = HALT;
         default: nxtState = FETCH;
      endcase
      // Keep the datapath quiet for the whole time reset is held
      if (reset) begin
         pcWrite  = 1'b0;
         irWrite  = 1'b0;
         iorD     = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
         regWrite = 1'b0;
         regDst   = 2'b00;
         memToReg = 2'b00;
         aluSrcA  = 1'b0;
         aluSrcB  = 2'b00;
         aluCtrl  = 3'b000;
         pcSrc    = 2'b00;
      end
   end

   assign halted  = (curState == HALT) & ~reset;
   assign illegal = illegalReg;
   assign state   = curState;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller: per-instruction
// cycle scripts feed an expectation queue that a negedge monitor drains.
module tb_multicycle_controller;
   localparam int CW = 4;

   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, memReady = 1'b0;
   logic [3:0] op = 4'd0;
   logic pcWrite, irWrite, iorD, memRead, memWrite, regWrite, aluSrcA, halted, illegal;
   logic [1:0] regDst, memToReg, aluSrcB, pcSrc;
   logic [2:0] aluCtrl;
   logic [3:0] state;
   logic [CW-1:0] retired;

   multicycle_controller #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtrl(aluCtrl), .pcSrc(pcSrc),
      .halted(halted), .illegal(illegal), .state(state), .retired(retired));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    st;
      logic [17:0]   ctl;
      logic [CW-1:0] ret;
      logic          ill;
      logic          hlt;
   } exp_t;

   exp_t expQ[$];
   logic [CW-1:0] retExp = '0;
   logic illExp = 1'b0, hltExp = 1'b0;
   int nChecks = 0, nPass = 0;

   function automatic logic [17:0] cv(input logic pw, iw, ad, mr, mw, rw,
                                      input logic [1:0] rd, m2r, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] ac,
                                      input logic [1:0] ps);
      return {pw, iw, ad, mr, mw, rw, rd, m2r, asa, asb, ac, ps};
   endfunction

   function automatic logic [2:0] aluOf(input logic [3:0] o);
      case (o)
         4'd1: return 3'b110;
         4'd2: return 3'b000;
         4'd3: return 3'b001;
         4'd4: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act === req) nPass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         chk("state", 32'(state), 32'(e.st));
         chk("ctl", 32'({pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg,
                         aluSrcA, aluSrcB, aluCtrl, pcSrc}), 32'(e.ctl));
         chk("retired", 32'(retired), 32'(e.ret));
         chk("illegal", 32'(illegal), 32'(e.ill));
         chk("halted", 32'(halted), 32'(e.hlt));
      end
   end

   task automatic cyc(input logic [3:0] st, input logic [17:0] c, input logic mr, input logic ret);
      memReady = mr;
      expQ.push_back('{st: st, ctl: c, ret: retExp, ill: illExp, hlt: hltExp});
      @(posedge clk); #1;
      if (ret) retExp = retExp + 1'b1;
   endtask

   // Reset pulse that lives entirely between two rising edges
   task automatic cycR();
      reset = 1'b1; memReady = 1'b0;
      retExp = '0; illExp = 1'b0; hltExp = 1'b0;
      expQ.push_back('{st: 4'd0, ctl: 18'd0, ret: '0, ill: 1'b0, hlt: 1'b0});
      @(negedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic fetchPart(input int wf);
      for (int i = 0; i < wf; i++) cyc(4'd0, cv(0,0,0,1,0,0,2'b00,2'b00,0,2'b01,3'b010,2'b00), 1'b0, 1'b0);
      cyc(4'd0, cv(1,1,0,1,0,0,2'b00,2'b00,0,2'b01,3'b010,2'b00), 1'b1, 1'b0);
      cyc(4'd1, cv(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00), 1'($urandom), 1'b0);
   endtask

   task automatic runInstr(input logic [3:0] o, input logic z, input int wf, input int wm, input int haltCyc);
      op = o; zero = z;
      fetchPart(wf);
      if (o <= 4'd4) begin
         cyc(4'd6, cv(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,aluOf(o),2'b00), 1'($urandom), 1'b0);
         cyc(4'd7, cv(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00), 1'($urandom), 1'b1);
      end else if (o == 4'd5) begin
         cyc(4'd6, cv(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00), 1'($urandom), 1'b0);
         cyc(4'd7, cv(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'($urandom), 1'b1);
      end else if (o == 4'd6) begin
         cyc(4'd2, cv(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00), 1'($urandom), 1'b0);
         for (int i = 0; i < wm; i++) cyc(4'd3, cv(0,0,1,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'b0, 1'b0);
         cyc(4'd3, cv(0,0,1,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'b1, 1'b0);
         cyc(4'd4, cv(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00), 1'($urandom), 1'b1);
      end else if (o == 4'd7) begin
         cyc(4'd2, cv(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00), 1'($urandom), 1'b0);
         for (int i = 0; i < wm; i++) cyc(4'd5, cv(0,0,1,0,1,0,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'b0, 1'b0);
         cyc(4'd5, cv(0,0,1,0,1,0,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'b1, 1'b1);
      end else if (o == 4'd8 || o == 4'd9) begin
         logic taken;
         taken = (o == 4'd8) ? z : ~z;
         cyc(4'd8, cv(taken,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01), 1'($urandom), 1'b1);
      end else if (o == 4'd10) begin
         cyc(4'd9, cv(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b10), 1'($urandom), 1'b1);
      end else if (o == 4'd11) begin
         cyc(4'd9, cv(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b10), 1'($urandom), 1'b1);
      end else if (o == 4'd15) begin
         hltExp = 1'b1;
         for (int i = 0; i < haltCyc; i++) cyc(4'd10, 18'd0, 1'($urandom), 1'b0);
      end else begin
         illExp = 1'b1;  // decode of an undefined opcode went straight back to fetch
      end
   endtask

   initial begin
      #1;
      cycR();
      runInstr(4'd0, 1'b0, 0, 0, 0);   // ADD: 0,1,6,7
      runInstr(4'd6, 1'b0, 3, 2, 0);   // LW with 3 fetch + 2 read waits
      runInstr(4'd8, 1'b1, 0, 0, 0);   // BEQ taken
      runInstr(4'd9, 1'b1, 0, 0, 0);   // BNE not taken
      runInstr(4'd11, 1'b0, 0, 0, 0);  // JAL
      runInstr(4'd12, 1'b0, 0, 0, 0);  // illegal
      runInstr(4'd7, 1'b0, 1, 2, 0);   // SW with waits, illegal stays set
      for (int n = 0; n < 150; n++) begin
         logic [3:0] o;
         o = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(12, 14)) : 4'($urandom_range(0, 11));
         runInstr(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      end
      // Reset during a stalled store
      op = 4'd7; zero = 1'b0;
      fetchPart(0);
      cyc(4'd2, cv(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00), 1'b0, 1'b0);
      cyc(4'd5, cv(0,0,1,0,1,0,2'b00,2'b00,0,2'b00,3'b000,2'b00), 1'b0, 1'b0);
      cycR();
      runInstr(4'd5, 1'b0, 0, 0, 0);
      runInstr(4'd13, 1'b0, 0, 0, 0);
      runInstr(4'd15, 1'b0, 0, 0, 6);  // HALT absorbs
      cycR();
      runInstr(4'd1, 1'b0, 1, 0, 0);
      repeat (2) @(posedge clk);
      chk("queue_drained", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
